uart_cfg: RTL

Parametrised full-duplex UART, successor to the fixed 8N1 UART: configurable data width, runtime baud divisor, optional even/odd parity, one or two stop bits, and per-byte receive error reporting. It sits between the core's memory-mapped I/O and the board pins. It buffers both directions in FIFOs with valid/ready handshakes, and it resynchronises the asynchronous receive pin.

---
 rtl/uart_pkg.sv | 11 +
 rtl/uart_cfg_if.sv | 9 +
 rtl/uart_fifo.sv | 40 ++++
 rtl/uart_cfg.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared state types, constants and parity helper for uart_cfg
package uart_pkg;
  localparam int MIN_DIV = 2;
  localparam int MAX_BITS = 9;
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} uart_tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} uart_rx_state_t;
  // callers zero-extend their DATA_BITS vector, which leaves the XOR unchanged
  function automatic logic parity(input logic [MAX_BITS-1:0] d, input logic odd);
    return ^d ^ odd;
  endfunction
endpackage

// File: rtl/uart_cfg_if.sv
// uart_cfg_if: core-side TX/RX FIFO handshake bundle of uart_cfg
interface uart_cfg_if #(parameter int DATA_BITS = 8);
  logic tx_valid, tx_ready, rx_valid, rx_ready, rx_frame_err, rx_parity_err, rx_overrun;
  logic [DATA_BITS-1:0] tx_data, rx_data;
  modport master(output tx_valid, tx_data, rx_ready,
                 input tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
  modport slave(input tx_valid, tx_data, rx_ready,
                output tx_ready, rx_valid, rx_data, rx_frame_err, rx_parity_err, rx_overrun);
endinterface

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-bit pointers; push ignored when full, pop when empty
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    full = wr_q[AW-1:0] == rd_q[AW-1:0] && wr_q[AW] != rd_q[AW];
    empty = wr_q == rd_q;
    do_push = push && !full;
    do_pop = pop && !empty;
    wr_d = wr_q + {{AW{1'b0}}, do_push};
    rd_d = rd_q + {{AW{1'b0}}, do_pop};
    dout = mem[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= din;
  end
endmodule

// File: rtl/uart_cfg.sv
// uart_cfg: full-duplex UART with runtime divisor, optional parity, 1/2 stop bits,
// TX/RX FIFOs and per-entry receive error flags
module uart_cfg import uart_pkg::*; #(
  parameter int DATA_BITS = 8,
  parameter int TX_FIFO = 16,
  parameter int RX_FIFO = 16,
  parameter int DIV_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic parity_en,
  input  logic parity_odd,
  input  logic two_stop,
  input  logic uart_rx,
  output logic uart_tx,
  uart_cfg_if.slave bus
);
  localparam int BW = $clog2(DATA_BITS);
  logic [DIV_W-1:0] div_eff;
  logic tx_empty, tx_full, tx_pop, tx_tick, tx_load;
  logic rx_empty, rx_full, rx_push, rx_tick;
  logic [DATA_BITS-1:0] tx_head;
  logic [DATA_BITS+1:0] rx_head;
  uart_tx_state_t tx_st_q, tx_st_d;
  uart_rx_state_t rx_st_q, rx_st_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d, rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic tx_pen_q, tx_pen_d, tx_par_q, tx_par_d, tx_two_q, tx_two_d, tx_line_q, tx_line_d;
  logic rx_pen_q, rx_pen_d, rx_odd_q, rx_odd_d, rx_perr_q, rx_perr_d, ovr_q, ovr_d;
  logic [2:0] rx_sync_q, rx_sync_d;
  assign div_eff = (divisor < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : divisor;
  assign uart_tx = tx_line_q;
  assign bus.tx_ready = !tx_full;
  assign bus.rx_valid = !rx_empty;
  assign bus.rx_overrun = ovr_q;
  assign bus.rx_parity_err = rx_head[DATA_BITS+1];
  assign bus.rx_frame_err = rx_head[DATA_BITS];
  assign bus.rx_data = rx_head[DATA_BITS-1:0];
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_FIFO)) u_tx_fifo (
    .clk, .rst, .push(bus.tx_valid), .pop(tx_pop), .din(bus.tx_data),
    .dout(tx_head), .full(tx_full), .empty(tx_empty));
  uart_fifo #(.WIDTH(DATA_BITS+2), .DEPTH(RX_FIFO)) u_rx_fifo (
    .clk, .rst, .push(rx_push), .pop(bus.rx_ready), .din({rx_perr_q, ~rx_sync_q[1], rx_sh_q}),
    .dout(rx_head), .full(rx_full), .empty(rx_empty));
  // STOP reloads straight into START so back-to-back frames have no idle gap
  always_comb begin
    tx_st_d = tx_st_q;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d = tx_sh_q;
    tx_pen_d = tx_pen_q;
    tx_par_d = tx_par_q;
    tx_two_d = tx_two_q;
    tx_tick = tx_cnt_q == tx_div_q - 1'b1;
    tx_cnt_d = (tx_st_q == TX_IDLE || tx_tick) ? '0 : tx_cnt_q + 1'b1;
    tx_load = 1'b0;
    case (tx_st_q)
      TX_IDLE: tx_load = !tx_empty;
      TX_START: if (tx_tick) tx_st_d = TX_DATA;
      TX_DATA: if (tx_tick) begin
        tx_sh_d = tx_sh_q >> 1;
        tx_bit_d = tx_bit_q + 1'b1;
        if (tx_bit_q == BW'(DATA_BITS - 1)) begin
          tx_bit_d = '0;
          tx_st_d = tx_pen_q ? TX_PARITY : TX_STOP;
        end
      end
      TX_PARITY: if (tx_tick) tx_st_d = TX_STOP;
      TX_STOP: if (tx_tick) begin
        if (tx_two_q && tx_bit_q == '0) tx_bit_d = BW'(1);
        else begin
          tx_st_d = TX_IDLE;
          tx_load = !tx_empty;
        end
      end
      default: tx_st_d = TX_IDLE;
    endcase
    tx_pop = tx_load;
    if (tx_load) begin
      tx_st_d = TX_START;
      tx_cnt_d = '0;
      tx_bit_d = '0;
      tx_sh_d = tx_head;
      tx_div_d = div_eff;
      tx_pen_d = parity_en;
      tx_two_d = two_stop;
      tx_par_d = parity(MAX_BITS'(tx_head), parity_odd);
    end
    tx_line_d = tx_st_q == TX_START ? 1'b0 : tx_st_q == TX_DATA ? tx_sh_q[0] :
                tx_st_q == TX_PARITY ? tx_par_q : 1'b1;
  end
  // rx_sync_q: [1] is the synchronised line, [2] its previous value for edge detection
  always_comb begin
    rx_sync_d = {rx_sync_q[1:0], uart_rx};
    rx_st_d = rx_st_q;
    rx_div_d = rx_div_q;
    rx_bit_d = rx_bit_q;
    rx_sh_d = rx_sh_q;
    rx_pen_d = rx_pen_q;
    rx_odd_d = rx_odd_q;
    rx_perr_d = rx_perr_q;
    rx_tick = rx_cnt_q == ((rx_st_q == RX_START) ? rx_div_q >> 1 : rx_div_q) - 1'b1;
    rx_cnt_d = (rx_st_q == RX_IDLE || rx_tick) ? '0 : rx_cnt_q + 1'b1;
    rx_push = 1'b0;
    case (rx_st_q)
      RX_IDLE: if (rx_sync_q[2] && !rx_sync_q[1]) begin
        rx_st_d = RX_START;
        rx_div_d = div_eff;
        rx_pen_d = parity_en;
        rx_odd_d = parity_odd;
        rx_perr_d = 1'b0;
      end
      RX_START: if (rx_tick) begin
        rx_st_d = rx_sync_q[1] ? RX_IDLE : RX_DATA;
        rx_bit_d = '0;
      end
      RX_DATA: if (rx_tick) begin
        rx_sh_d = {rx_sync_q[1], rx_sh_q[DATA_BITS-1:1]};
        rx_bit_d = rx_bit_q + 1'b1;
        if (rx_bit_q == BW'(DATA_BITS - 1)) rx_st_d = rx_pen_q ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_tick) begin
        rx_perr_d = rx_sync_q[1] != parity(MAX_BITS'(rx_sh_q), rx_odd_q);
        rx_st_d = RX_STOP;
      end
      RX_STOP: if (rx_tick) begin
        rx_push = 1'b1;
        rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
    ovr_d = rx_push && rx_full;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_st_q <= TX_IDLE;
      tx_cnt_q <= '0;
      tx_div_q <= DIV_W'(MIN_DIV);
      tx_bit_q <= '0;
      tx_sh_q <= '0;
      tx_pen_q <= 1'b0;
      tx_par_q <= 1'b0;
      tx_two_q <= 1'b0;
      tx_line_q <= 1'b1;
      rx_st_q <= RX_IDLE;
      rx_cnt_q <= '0;
      rx_div_q <= DIV_W'(MIN_DIV);
      rx_bit_q <= '0;
      rx_sh_q <= '0;
      rx_pen_q <= 1'b0;
      rx_odd_q <= 1'b0;
      rx_perr_q <= 1'b0;
      rx_sync_q <= '1;
      ovr_q <= 1'b0;
    end else begin
      tx_st_q <= tx_st_d;
      tx_cnt_q <= tx_cnt_d;
      tx_div_q <= tx_div_d;
      tx_bit_q <= tx_bit_d;
      tx_sh_q <= tx_sh_d;
      tx_pen_q <= tx_pen_d;
      tx_par_q <= tx_par_d;
      tx_two_q <= tx_two_d;
      tx_line_q <= tx_line_d;
      rx_st_q <= rx_st_d;
      rx_cnt_q <= rx_cnt_d;
      rx_div_q <= rx_div_d;
      rx_bit_q <= rx_bit_d;
      rx_sh_q <= rx_sh_d;
      rx_pen_q <= rx_pen_d;
      rx_odd_q <= rx_odd_d;
      rx_perr_q <= rx_perr_d;
      rx_sync_q <= rx_sync_d;
      ovr_q <= ovr_d;
    end
  end
endmodule
